// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t  : sequencer states
//   CNT_W    : width of the dwell/timeout cycle counter
//   RETRY_W  : width of the retry counter
//   LOSS_W   : width of the saturating lock-loss counter
//   last_cnt : converts a cycle count into the terminal counter value
package pll_seq_pkg;

    localparam int CNT_W   = 20;
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // A dwell of N cycles ends when the counter (starting at 0) reads N-1.
    function automatic logic [CNT_W-1:0] last_cnt(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
//   clk    : destination clock
//   resetn : synchronous active-low reset, clears both flops
//   d      : asynchronous input
//   q      : synchronized output, two clk edges of latency
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with a bounded
// number of retries, requires lock to stay up for a dwell period before
// asserting ready, and re-runs the sequence whenever lock is lost.
//   clkin         : PLL reference clock, the only clock
//   resetn        : synchronous active-low reset
//   pll_lock      : PLL lock, asynchronous to clkin
//   restart       : single-cycle request to restart the sequence
//   pll_reset     : PLL reset, active-high
//   ready         : PLL locked and stable
//   fail          : retries exhausted, held until restart or reset
//   retries       : lock timeouts in the current sequence
//   lock_loss_cnt : lock drops seen while running, saturating
//   fsm_state     : current sequencer state (observability)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               clkin,
    input  logic               resetn,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retries,
    output logic [LOSS_W-1:0]  lock_loss_cnt,
    output state_t             fsm_state
);

    localparam logic [CNT_W-1:0]   RST_LAST    = last_cnt(RST_CYCLES);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = last_cnt(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0]   STABLE_LAST = last_cnt(STABLE_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retries_next;
    logic [LOSS_W-1:0]  loss_next;

    sync_2ff u_lock_sync (
        .clk    (clkin),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    always_comb begin
        state_next   = state;
        retries_next = retries;
        loss_next    = lock_loss_cnt;
        if (restart) begin
            state_next   = ST_RESET_PLL;
            retries_next = '0;
        end else begin
            case (state)
                ST_RESET_PLL: begin
                    if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as a lock.
                    if (lock_s) begin
                        state_next = ST_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retries < RETRY_MAX) begin
                            retries_next = retries + RETRY_W'(1);
                            state_next   = ST_RESET_PLL;
                        end else begin
                            state_next = ST_FAIL;
                        end
                    end
                end
                ST_STABLE: begin
                    // A glitch during the dwell is not a timeout: retries untouched.
                    if (!lock_s) state_next = ST_WAIT_LOCK;
                    else if (cnt == STABLE_LAST) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_next   = ST_RESET_PLL;
                        retries_next = '0;
                        if (lock_loss_cnt != '1) loss_next = lock_loss_cnt + LOSS_W'(1);
                    end
                end
                ST_FAIL: state_next = ST_FAIL;
                default: state_next = ST_RESET_PLL;
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as state.
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            state         <= ST_RESET_PLL;
            cnt           <= '0;
            pll_reset     <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retries       <= '0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_next;
            // Restart re-enters RESET_PLL from RESET_PLL too, so it also clears.
            cnt           <= (restart || (state_next != state)) ? '0 : cnt + CNT_W'(1);
            retries       <= retries_next;
            lock_loss_cnt <= loss_next;
            pll_reset     <= (state_next == ST_RESET_PLL) || (state_next == ST_FAIL);
            ready         <= (state_next == ST_RUN);
            fail          <= (state_next == ST_FAIL);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int RST_C = 4;
    localparam int TO_C  = 32;
    localparam int ST_C  = 8;
    localparam int MAX_R = 2;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retries;
    logic [7:0] lock_loss_cnt;
    state_t     fsm_state;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (ST_C),
        .MAX_RETRIES   (MAX_R)
    ) dut (
        .clkin         (clk),
        .resetn        (resetn),
        .pll_lock      (pll_lock),
        .restart       (restart),
        .pll_reset     (pll_reset),
        .ready         (ready),
        .fail          (fail),
        .retries       (retries),
        .lock_loss_cnt (lock_loss_cnt),
        .fsm_state     (fsm_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Phases with their dwell lengths; the sync is a 2-deep history of lock samples.
    localparam int PH_RST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;
    int dwell [5] = '{RST_C, TO_C, ST_C, 0, 0};
    int m_phase, m_elapsed, m_retries, m_losses, m_next;
    bit m_hist[$];
    bit m_valid = 1'b0;
    bit m_ls, m_expired;
    logic [14:0] exp_q[$];
    logic [14:0] exp_word, got_word;

    always @(posedge clk) begin
        if (!resetn) begin
            m_phase = PH_RST; m_elapsed = 0; m_retries = 0; m_losses = 0;
            m_hist = '{1'b0, 1'b0};
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_ls = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(pll_lock);
            m_next = m_phase;
            m_expired = (m_elapsed + 1 == dwell[m_phase]);
            if (restart) begin
                m_next = PH_RST;
                m_retries = 0;
            end else if (m_phase == PH_RST) begin
                if (m_expired) m_next = PH_WAIT;
            end else if (m_phase == PH_WAIT) begin
                if (m_ls) m_next = PH_STABLE;
                else if (m_expired) begin
                    if (m_retries < MAX_R) begin m_retries++; m_next = PH_RST; end
                    else m_next = PH_FAIL;
                end
            end else if (m_phase == PH_STABLE) begin
                if (!m_ls) m_next = PH_WAIT;
                else if (m_expired) m_next = PH_RUN;
            end else if (m_phase == PH_RUN) begin
                if (!m_ls) begin m_next = PH_RST; m_retries = 0; m_losses++; end
            end
            m_elapsed = (restart || m_next != m_phase) ? 0 : m_elapsed + 1;
            m_phase = m_next;
        end
        if (m_valid)
            exp_q.push_back({(m_phase == PH_RST || m_phase == PH_FAIL), (m_phase == PH_RUN),
                             (m_phase == PH_FAIL), 4'(m_retries), 8'((m_losses > 255) ? 255 : m_losses)});
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            got_word = {pll_reset, ready, fail, retries, lock_loss_cnt};
            checks++;
            if (got_word !== exp_word) begin
                errors++;
                $display("FAIL model: got %h expected %h at %0t", got_word, exp_word, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit rn, input bit rs, input bit lk);
        resetn = rn; restart = rs; pll_lock = lk;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        step(1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rn; bit rs; bit lk; int cycles;
        bit e_rst; bit e_ready; bit e_fail; int e_retries; int e_loss;
    } vec_t;
    vec_t vecs [16];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int mism;
        bit e_hi;
        int hold;

        // Bring-up, lock loss in RUN, restart in RUN.
        vecs[0]  = '{0, 0, 0,  1, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0,  3, 1, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0,  1, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0,  9, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 1, 10, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 1,  1, 0, 1, 0, 0, 0};
        vecs[6]  = '{1, 0, 0,  2, 0, 1, 0, 0, 0};
        vecs[7]  = '{1, 0, 0,  1, 1, 0, 0, 0, 1};
        vecs[8]  = '{1, 0, 0,  3, 1, 0, 0, 0, 1};
        vecs[9]  = '{1, 0, 0,  1, 0, 0, 0, 0, 1};
        vecs[10] = '{1, 0, 1, 11, 0, 1, 0, 0, 1};
        vecs[11] = '{1, 1, 1,  1, 1, 0, 0, 0, 1};
        vecs[12] = '{1, 0, 1,  3, 1, 0, 0, 0, 1};
        vecs[13] = '{1, 0, 1,  1, 0, 0, 0, 0, 1};
        vecs[14] = '{1, 0, 1,  8, 0, 0, 0, 0, 1};
        vecs[15] = '{1, 0, 1,  1, 0, 1, 0, 0, 1};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rn, vecs[i].rs, vecs[i].lk);
            step(vecs[i].cycles);
            check($sformatf("vec%0d_pll_reset", i), pll_reset, vecs[i].e_rst);
            check($sformatf("vec%0d_ready", i), ready, vecs[i].e_ready);
            check($sformatf("vec%0d_fail", i), fail, vecs[i].e_fail);
            check($sformatf("vec%0d_retries", i), retries, vecs[i].e_retries);
            check($sformatf("vec%0d_loss", i), lock_loss_cnt, vecs[i].e_loss);
        end

        // Reset pulse while waiting for lock clears everything.
        drive(1'b1, 1'b0, 1'b0);
        step(3);
        check("run_drop_ready", ready, 0);
        check("run_drop_loss", lock_loss_cnt, 2);
        step(4);
        check("pre_reset_in_wait", pll_reset, 0);
        do_reset();
        check("midreset_pll_reset", pll_reset, 1);
        check("midreset_ready", ready, 0);
        check("midreset_fail", fail, 0);
        check("midreset_retries", retries, 0);
        check("midreset_loss", lock_loss_cnt, 0);

        // Lock glitch in the middle of the stable dwell.
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        step(8);
        pll_lock = 1'b0;
        step(3);
        check("glitch_ready", ready, 0);
        check("glitch_retries", retries, 0);
        pll_lock = 1'b1;
        n = 0;
        while (!ready && n < 40) begin step(1); n++; end
        check("glitch_relock_latency", n, 11);
        check("glitch_retries_after", retries, 0);

        // 256 lock losses saturate the counter.
        for (int i = 0; i < 256; i++) begin
            pll_lock = 1'b0;
            n = 0;
            while (ready && n < 10) begin step(1); n++; end
            check("loss_ready_fall", ready, 0);
            if (i == 0) check("loss_first", lock_loss_cnt, 1);
            if (i >= 254) check($sformatf("loss_sat_%0d", i + 1), lock_loss_cnt, 255);
            pll_lock = 1'b1;
            n = 0;
            while (!ready && n < 100) begin step(1); n++; end
            check("loss_relock", ready, 1);
        end

        // Lock never arrives: three 4-cycle pulses, 32-cycle waits, then FAIL.
        do_reset();
        mism = (pll_reset !== 1'b1 || fail !== 1'b0) ? 1 : 0;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 118; i++) begin
            step(1);
            e_hi = (i >= 108) ? 1'b1 : ((i % 36) < 4);
            if (pll_reset !== e_hi || fail !== (i >= 108)) mism++;
        end
        check("nolock_pattern_mismatches", mism, 0);
        check("nolock_fail", fail, 1);
        check("nolock_retries", retries, 2);
        check("nolock_pll_reset", pll_reset, 1);

        // Restart out of FAIL.
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("restart_fail", fail, 0);
        check("restart_retries", retries, 0);
        check("restart_pll_reset", pll_reset, 1);
        step(3);
        check("restart_pulse_hi", pll_reset, 1);
        step(1);
        check("restart_pulse_lo", pll_reset, 0);

        // Restart on the timeout cycle wins over the timeout.
        step(31);
        check("tie_pre_pll_reset", pll_reset, 0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("tie_retries", retries, 0);
        check("tie_pll_reset", pll_reset, 1);
        step(3);
        check("tie_pulse_hi", pll_reset, 1);
        step(1);
        check("tie_pulse_lo", pll_reset, 0);
        step(32);
        check("timeout_retries", retries, 1);
        check("timeout_pll_reset", pll_reset, 1);

        // Randomized traffic, checked against the model every cycle.
        for (int seg = 0; seg < 150; seg++) begin
            hold = $urandom_range(1, 120);
            pll_lock = 1'($urandom_range(0, 1));
            for (int k = 0; k < hold; k++) begin
                restart = ($urandom_range(0, 59) == 0);
                resetn  = ($urandom_range(0, 399) != 0);
                step(1);
            end
            restart = 1'b0;
            resetn  = 1'b1;
        end

        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse width in clkin cycles, legal range 2..2^20.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: clkin cycles to wait for lock per attempt, legal range 2..2^20.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: cycles lock must stay high before ready asserts, legal range 2..2^20.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: re-reset attempts after a timeout before failing, legal range 0..15.
REQ-005 SHALL have port clkin, input, 1 bit: the single clock (PLL reference clock).
REQ-006 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port pll_lock, input, 1 bit: PLL lock, asynchronous to clkin.
REQ-008 SHALL have port restart, input, 1 bit: single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives the PLL reset input, active-high.
REQ-010 SHALL have port ready, output, 1 bit: PLL locked and stable; downstream reset may release.
REQ-011 SHALL have port fail, output, 1 bit: retries exhausted.
REQ-012 SHALL have port retries, output, 4 bits: timeouts counted in the current sequence.
REQ-013 SHALL have port lock_loss_cnt, output, 8 bits: lock drops seen in RUN, saturating.

Function
REQ-014 SHALL pass pll_lock through a 2-flop synchronizer (lock_s); the FSM uses only lock_s.
REQ-015 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL, plus one 20-bit cycle counter that clears on every state change.
REQ-016 RESET_PLL: pll_reset=1; when counter==RST_CYCLES-1, go to WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_reset=0.
REQ-018 WAIT_LOCK: lock_s=1 goes to STABLE.
REQ-019 WAIT_LOCK: when counter==LOCK_TIMEOUT-1 and retries<MAX_RETRIES, increment retries and go to RESET_PLL; otherwise go to FAIL.
REQ-020 WAIT_LOCK: lock_s=1 has priority over timeout on the same cycle.
REQ-021 STABLE: lock_s=0 returns to WAIT_LOCK with a fresh timeout and retries unchanged; when counter==STABLE_CYCLES-1 with lock_s=1, go to RUN.
REQ-022 RUN: ready=1; lock_s=0 goes to RESET_PLL, increments lock_loss_cnt (saturates at 255) and clears retries.
REQ-023 FAIL: fail=1, pll_reset=1 held; FAIL is exited only by restart or reset.
REQ-024 restart=1 in any state SHALL go to RESET_PLL, clear retries and clear fail; restart has priority over all other transitions.
REQ-025 SHALL register all outputs as a Moore decode of the next state, so each output changes on the same edge as the state.
REQ-026 Latency: ready SHALL rise on the (STABLE_CYCLES+3)th rising edge after pll_lock rises, counting 2 sync, 1 transition and STABLE_CYCLES dwell edges.
REQ-027 Latency: ready SHALL fall on the 3rd edge after pll_lock falls.

Reset
REQ-028 resetn=0 sampled at a clkin edge SHALL force: state RESET_PLL, counter 0, pll_reset=1, ready=0, fail=0, retries=0, lock_loss_cnt=0, synchronizer flops 0.
REQ-029 resetn asserted mid-sequence SHALL abort at the next edge with no partial state retained.
REQ-030 After resetn rises, the RST_CYCLES pulse starts counting from 0.

Structure
REQ-031 Package pll_seq_pkg SHALL hold the state enum, CNT_W=20, RETRY_W=4 and LOSS_W=8.
REQ-032 Sub-module sync_2ff SHALL implement the lock synchronizer.
REQ-033 The FSM, counter and output registers SHALL reside in pll_reset_sequencer.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-034 Normal bring-up: pll_lock rises 10 cycles after pll_reset falls -> ready=1 exactly 11 edges later; retries=0; fail=0.
REQ-035 Lock never asserts -> exactly 3 pll_reset pulses, each 4 cycles wide, separated by 32-cycle waits; then fail=1, retries=2, pll_reset stays 1.
REQ-036 Lock low for 3 cycles midway through STABLE -> ready stays 0, retries stays 0; ready rises 11 edges after lock recovers.
REQ-037 Lock drop in RUN -> ready=0 on the 3rd edge, pll_reset pulses 4 cycles, lock_loss_cnt 0->1; re-lock restores ready.
REQ-038 restart pulse in FAIL -> fail=0 and retries=0 next edge, new 4-cycle pll_reset pulse.
REQ-039 Simultaneous restart and timeout -> restart wins.
REQ-040 resetn low for 1 cycle during WAIT_LOCK -> all outputs at reset values on that edge.
REQ-041 256 lock losses -> lock_loss_cnt saturates at 255.
